// File: rtl/scara_pkg.sv
// Shared types for the SCARA inverse-kinematics sequencer: stage indices,
// sequencer states, error codes and small stage helpers.
package scara_pkg;

    localparam int NUM_STAGES = 5;

    typedef enum logic [2:0] {
        STG_FK   = 3'd0,
        STG_J    = 3'd1,
        STG_JI   = 3'd2,
        STG_MULT = 3'd3,
        STG_CONV = 3'd4
    } stage_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PREP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_CHECK = 3'd3,
        ST_ACCUM = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAULT = 3'd6
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_OK      = 2'b00,
        ERR_TIMEOUT = 2'b01,
        ERR_ITER    = 2'b10,
        ERR_ABORT   = 2'b11
    } err_code_e;

    function automatic stage_e next_stage(input stage_e s);
        case (s)
            STG_FK:   return STG_J;
            STG_J:    return STG_JI;
            STG_JI:   return STG_MULT;
            STG_MULT: return STG_CONV;
            default:  return STG_FK;
        endcase
    endfunction

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_e s);
        logic [NUM_STAGES-1:0] oh;
        oh = '0;
        oh[s] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/step_accumulator.sv
// Saturating signed adder for one joint's absolute step command; o_clamp
// flags that the true sum fell outside the STEP_W signed range.
module step_accumulator #(
    parameter int STEP_W = 9
) (
    input  logic signed [STEP_W-1:0] i_acc,
    input  logic signed [STEP_W-1:0] i_delta,
    output logic signed [STEP_W-1:0] o_sum,
    output logic                     o_clamp
);

    logic signed [STEP_W:0] w_wide;

    assign w_wide = {i_acc[STEP_W-1], i_acc} + {i_delta[STEP_W-1], i_delta};

    // The two top bits disagree exactly when the sum left the narrow range.
    always_comb begin
        o_clamp = 1'b0;
        o_sum   = w_wide[STEP_W-1:0];
        if (w_wide[STEP_W] != w_wide[STEP_W-1]) begin
            o_clamp = 1'b1;
            o_sum   = w_wide[STEP_W] ? {1'b1, {(STEP_W-1){1'b0}}}
                                     : {1'b0, {(STEP_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/scara_ik_sequencer.sv
// Iterative SCARA IK sequencer: walks FK/J/JI/MULT/CONV stages until the FK
// position is within tolerance. Define IK_WATCHDOG_EN to add the per-stage watchdog.
module scara_ik_sequencer
    import scara_pkg::*;
#(
    parameter int COORD_W     = 14,
    parameter int STEP_W      = 9,
    parameter int MAX_ITER    = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic signed [COORD_W-1:0]        x_target,
    input  logic signed [COORD_W-1:0]        y_target,
    input  logic        [COORD_W-1:0]        tol,
    input  logic signed [COORD_W-1:0]        x_fk,
    input  logic signed [COORD_W-1:0]        y_fk,
    input  logic signed [STEP_W-1:0]         d1_steps,
    input  logic signed [STEP_W-1:0]         d2_steps,
    input  logic        [NUM_STAGES-1:0]     stage_done,
    output logic        [NUM_STAGES-1:0]     stage_en,
    output logic                             stage_rst,
    output logic signed [STEP_W-1:0]         th1_steps,
    output logic signed [STEP_W-1:0]         th2_steps,
    output logic                             step_valid,
    output logic                             busy,
    output logic                             done,
    output logic                             converged,
    output logic                             sat,
    output logic        [1:0]                err_code,
    output logic [$clog2(MAX_ITER+1)-1:0]    iter_cnt
);

    localparam int IW = $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0] ITER_LIMIT = IW'(MAX_ITER);

    seq_state_e r_state, w_state_next;
    stage_e     r_cur, w_cur_next;

    logic signed [COORD_W-1:0] r_tgt [2];
    logic signed [COORD_W-1:0] r_fk  [2];
    logic        [COORD_W-1:0] r_tol;
    logic signed [STEP_W-1:0]  r_d   [2];
    logic signed [STEP_W-1:0]  r_th  [2];
    logic                      r_step_valid;
    logic                      r_converged;
    logic                      r_sat;
    err_code_e                 r_err;
    logic        [IW-1:0]      r_iter;

    logic signed [COORD_W-1:0] w_tgt_in [2];
    logic signed [COORD_W-1:0] w_fk_in  [2];
    logic signed [STEP_W-1:0]  w_d_in   [2];
    logic signed [STEP_W-1:0]  w_sum    [2];
    logic        [1:0]         w_clamp;
    logic        [1:0]         w_within;
    logic                      w_in_tol;
    logic                      w_stage_hit;
    logic                      w_wd_expire;
    logic [NUM_STAGES-1:0]     w_stage_en;
    logic                      w_stage_rst;
    logic                      w_busy;
    logic                      w_done;

    assign w_tgt_in[0] = x_target;
    assign w_tgt_in[1] = y_target;
    assign w_fk_in[0]  = x_fk;
    assign w_fk_in[1]  = y_fk;
    assign w_d_in[0]   = d1_steps;
    assign w_d_in[1]   = d2_steps;

    // Error magnitude is taken one bit wider so the difference never wraps.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_axis
            logic signed [COORD_W:0] w_diff;
            logic        [COORD_W:0] w_abs;
            assign w_diff = {r_tgt[gi][COORD_W-1], r_tgt[gi]} - {r_fk[gi][COORD_W-1], r_fk[gi]};
            assign w_abs  = w_diff[COORD_W] ? (COORD_W+1)'(-w_diff) : w_diff;
            assign w_within[gi] = (w_abs <= {1'b0, r_tol});
        end

        for (gi = 0; gi < 2; gi++) begin : g_joint
            step_accumulator #(.STEP_W(STEP_W)) u_acc (
                .i_acc   (r_th[gi]),
                .i_delta (r_d[gi]),
                .o_sum   (w_sum[gi]),
                .o_clamp (w_clamp[gi])
            );
        end
    endgenerate

    assign w_in_tol    = &w_within;
    assign w_stage_hit = (r_state == ST_RUN) && stage_done[r_cur];

`ifdef IK_WATCHDOG_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);
    logic [WDW-1:0] r_wd_cnt;

    always_ff @(posedge clk) begin
        if (reset || r_state != ST_RUN) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    assign w_wd_expire = (r_state == ST_RUN) && (r_wd_cnt == WDW'(TIMEOUT_CYC - 1));
`else
    // TIMEOUT_CYC has no effect without the watchdog; RUN waits indefinitely.
    assign w_wd_expire = 1'b0 && (TIMEOUT_CYC >= 2);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cur   <= STG_FK;
        end else begin
            r_state <= w_state_next;
            r_cur   <= w_cur_next;
        end
    end

    // Abort outranks stage completion, convergence and watchdog expiry.
    always_comb begin
        w_state_next = r_state;
        w_cur_next   = r_cur;
        w_stage_en   = '0;
        w_stage_rst  = 1'b1;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_PREP;
                    w_cur_next   = STG_FK;
                end
            end
            ST_PREP: begin
                w_busy       = 1'b1;
                w_state_next = abort ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                w_busy      = 1'b1;
                w_stage_rst = 1'b0;
                w_stage_en  = stage_onehot(r_cur);
                if (abort) begin
                    w_state_next = ST_DONE;
                end else if (w_stage_hit) begin
                    if (r_cur == STG_FK) begin
                        w_state_next = ST_CHECK;
                    end else if (r_cur == STG_CONV) begin
                        w_state_next = ST_ACCUM;
                    end else begin
                        w_cur_next   = next_stage(r_cur);
                        w_state_next = ST_PREP;
                    end
                end else if (w_wd_expire) begin
                    w_state_next = ST_FAULT;
                end
            end
            ST_CHECK: begin
                w_busy = 1'b1;
                if (abort || w_in_tol || r_iter == ITER_LIMIT) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cur_next   = STG_J;
                    w_state_next = ST_PREP;
                end
            end
            ST_ACCUM: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_cur_next   = STG_FK;
                    w_state_next = ST_PREP;
                end
            end
            ST_DONE, ST_FAULT: begin
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < 2; j++) begin
                r_tgt[j] <= '0;
                r_fk[j]  <= '0;
                r_d[j]   <= '0;
                r_th[j]  <= '0;
            end
            r_tol        <= '0;
            r_step_valid <= 1'b0;
            r_converged  <= 1'b0;
            r_sat        <= 1'b0;
            r_err        <= ERR_OK;
            r_iter       <= '0;
        end else begin
            r_step_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        for (int j = 0; j < 2; j++) r_tgt[j] <= w_tgt_in[j];
                        r_tol       <= tol;
                        r_iter      <= '0;
                        r_sat       <= 1'b0;
                        r_converged <= 1'b0;
                        r_err       <= ERR_OK;
                    end
                end
                ST_PREP: begin
                    if (abort) r_err <= ERR_ABORT;
                end
                ST_RUN: begin
                    if (w_stage_hit && r_cur == STG_FK) begin
                        for (int j = 0; j < 2; j++) r_fk[j] <= w_fk_in[j];
                    end
                    if (w_stage_hit && r_cur == STG_CONV) begin
                        for (int j = 0; j < 2; j++) r_d[j] <= w_d_in[j];
                    end
                    if (abort) begin
                        r_err <= ERR_ABORT;
                    end else if (!w_stage_hit && w_wd_expire) begin
                        r_err <= ERR_TIMEOUT;
                    end
                end
                ST_CHECK: begin
                    if (abort) begin
                        r_err <= ERR_ABORT;
                    end else if (w_in_tol) begin
                        r_converged <= 1'b1;
                        r_err       <= ERR_OK;
                    end else if (r_iter == ITER_LIMIT) begin
                        r_err <= ERR_ITER;
                    end
                end
                ST_ACCUM: begin
                    // The accumulation commits even when abort lands on this cycle.
                    for (int j = 0; j < 2; j++) r_th[j] <= w_sum[j];
                    r_sat        <= r_sat | (|w_clamp);
                    r_step_valid <= 1'b1;
                    r_iter       <= r_iter + 1'b1;
                    if (abort) r_err <= ERR_ABORT;
                end
                default: begin
                end
            endcase
        end
    end

    assign stage_en   = w_stage_en;
    assign stage_rst  = w_stage_rst;
    assign busy       = w_busy;
    assign done       = w_done;
    assign th1_steps  = r_th[0];
    assign th2_steps  = r_th[1];
    assign step_valid = r_step_valid;
    assign converged  = r_converged;
    assign sat        = r_sat;
    assign err_code   = r_err;
    assign iter_cnt   = r_iter;

endmodule

// File: tb/tb_scara_ik_sequencer.sv
// Directed bench for scara_ik_sequencer with stub compute stages; the watchdog
// step expects a FAULT when IK_WATCHDOG_EN is defined and a hang-then-abort otherwise.
module tb_scara_ik_sequencer;

    localparam int COORD_W     = 14;
    localparam int STEP_W      = 9;
    localparam int MAX_ITER    = 4;
    localparam int TIMEOUT_CYC = 8;
    localparam int IW          = $clog2(MAX_ITER + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       reset, start, abort;
    logic signed [COORD_W-1:0]  x_target, y_target, x_fk, y_fk;
    logic        [COORD_W-1:0]  tol;
    logic signed [STEP_W-1:0]   d1_steps, d2_steps, th1_steps, th2_steps;
    logic        [4:0]          stage_done, stage_en, hang_mask;
    logic                       stage_rst, step_valid, busy, done, converged, sat;
    logic        [1:0]          err_code;
    logic        [IW-1:0]       iter_cnt;

    logic signed [COORD_W-1:0]  fk_x_tab [0:7];
    logic signed [COORD_W-1:0]  fk_y_tab [0:7];

    int checks   = 0;
    int failures = 0;
    int sv_total = 0;
    int done_total = 0;
    int run_no   = 0;

    scara_ik_sequencer #(
        .COORD_W(COORD_W), .STEP_W(STEP_W), .MAX_ITER(MAX_ITER), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .x_target(x_target), .y_target(y_target), .tol(tol),
        .x_fk(x_fk), .y_fk(y_fk), .d1_steps(d1_steps), .d2_steps(d2_steps),
        .stage_done(stage_done), .stage_en(stage_en), .stage_rst(stage_rst),
        .th1_steps(th1_steps), .th2_steps(th2_steps), .step_valid(step_valid),
        .busy(busy), .done(done), .converged(converged), .sat(sat),
        .err_code(err_code), .iter_cnt(iter_cnt)
    );

    // Stub stages finish in their first RUN cycle unless masked; FK answers per pass.
    always_comb begin
        stage_done = stage_en & ~hang_mask;
        x_fk = fk_x_tab[iter_cnt];
        y_fk = fk_y_tab[iter_cnt];
    end

    always @(posedge clk) begin
        if (step_valid === 1'b1) sv_total++;
        if (done === 1'b1) done_total++;
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_run(input logic signed [COORD_W-1:0] xt, input logic signed [COORD_W-1:0] yt,
                          input logic [COORD_W-1:0] tl, input logic with_abort);
        x_target = xt; y_target = yt; tol = tl; start = 1'b1; abort = with_abort;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        x_target = '0; y_target = '0; tol = '0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("done_within_budget", done, 1);
    endtask

    task automatic report(input int cyc);
        run_no++;
        $display("run %0d: err=%0d conv=%0d iter=%0d th1=%0d th2=%0d sat=%0d cyc=%0d",
                 run_no, err_code, converged, iter_cnt, th1_steps, th2_steps, sat, cyc);
    endtask

    task automatic set_fk(input int idx, input int x, input int y);
        fk_x_tab[idx] = COORD_W'(x);
        fk_y_tab[idx] = COORD_W'(y);
    endtask

    initial begin
        int cyc, sv0, dn0, c;
        reset = 1'b1; start = 1'b0; abort = 1'b0; x_target = '0; y_target = '0; tol = '0;
        d1_steps = '0; d2_steps = '0; hang_mask = '0;
        for (int i = 0; i < 8; i++) set_fk(i, 0, 0);
        repeat (3) @(negedge clk);

        check("rst_stage_en", stage_en, 0);
        check("rst_stage_rst", stage_rst, 1);
        check("rst_th1", th1_steps, 0);
        check("rst_th2", th2_steps, 0);
        check("rst_step_valid", step_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_converged", converged, 0);
        check("rst_sat", sat, 0);
        check("rst_err", err_code, 0);
        check("rst_iter", iter_cnt, 0);
        reset = 1'b0;
        @(negedge clk);

        // Exact hit on the first FK pass.
        set_fk(0, 200, -30);
        sv0 = sv_total; dn0 = done_total;
        do_run(200, -30, 0, 1'b0);
        check("t1_prep_busy", busy, 1);
        check("t1_prep_stage_rst", stage_rst, 1);
        check("t1_prep_stage_en", stage_en, 0);
        @(negedge clk);
        check("t1_run_stage_en", stage_en, 5'b00001);
        check("t1_run_stage_rst", stage_rst, 0);
        wait_done(20, cyc);
        check("t1_latency", cyc, 2);
        check("t1_err", err_code, 0);
        check("t1_conv", converged, 1);
        check("t1_iter", iter_cnt, 0);
        check("t1_busy_in_done", busy, 0);
        report(cyc);
        @(negedge clk);
        check("t1_done_pulses", done_total - dn0, 1);
        check("t1_no_step_valid", sv_total - sv0, 0);
        check("t1_done_low", done, 0);

        // One correction iteration.
        set_fk(0, 90, 40); set_fk(1, 99, 49);
        d1_steps = 9'sd3; d2_steps = -9'sd2;
        sv0 = sv_total; dn0 = done_total;
        do_run(100, 50, 2, 1'b0);
        wait_done(60, cyc);
        check("t2_latency", cyc, 15);
        check("t2_th1", th1_steps, 3);
        check("t2_th2", th2_steps, -2);
        check("t2_iter", iter_cnt, 1);
        check("t2_conv", converged, 1);
        check("t2_err", err_code, 0);
        report(cyc);
        @(negedge clk);
        check("t2_step_valid_cnt", sv_total - sv0, 1);
        check("t2_done_pulses", done_total - dn0, 1);

        // Never converges: iteration limit.
        for (int i = 0; i < 8; i++) set_fk(i, 0, 0);
        sv0 = sv_total;
        do_run(1000, 1000, 5, 1'b0);
        wait_done(200, cyc);
        check("t3_latency", cyc, 51);
        check("t3_err", err_code, 2);
        check("t3_conv", converged, 0);
        check("t3_iter", iter_cnt, 4);
        check("t3_th1", th1_steps, 15);
        check("t3_th2", th2_steps, -10);
        report(cyc);
        @(negedge clk);
        check("t3_step_valid_cnt", sv_total - sv0, 4);

        // Walk th1 up to 250, then push both joints past their limits.
        set_fk(0, 0, 0); set_fk(1, 7, 7);
        d1_steps = 9'sd235; d2_steps = 9'sd0;
        do_run(7, 7, 0, 1'b0);
        wait_done(60, cyc);
        check("t4a_th1", th1_steps, 250);
        check("t4a_sat", sat, 0);
        report(cyc);
        @(negedge clk);
        d1_steps = 9'sd10; d2_steps = -9'sd250;
        do_run(7, 7, 0, 1'b0);
        wait_done(60, cyc);
        check("t4b_th1_clamp", th1_steps, 255);
        check("t4b_th2_clamp", th2_steps, -256);
        check("t4b_sat", sat, 1);
        check("t4b_conv", converged, 1);
        report(cyc);
        @(negedge clk);

        // Error exactly equal to tol converges; start together with abort still runs.
        set_fk(0, -8, 10);
        do_run(-5, 7, 3, 1'b1);
        check("t4c_sat_cleared", sat, 0);
        check("t4c_busy", busy, 1);
        wait_done(20, cyc);
        check("t4c_latency", cyc, 3);
        check("t4c_err", err_code, 0);
        check("t4c_conv", converged, 1);
        check("t4c_th1_persist", th1_steps, 255);
        check("t4c_th2_persist", th2_steps, -256);
        report(cyc);
        @(negedge clk);

        // One count outside tol forces an iteration.
        set_fk(0, -9, 7); set_fk(1, -5, 10);
        d1_steps = 9'sd0; d2_steps = 9'sd0;
        do_run(-5, 7, 3, 1'b0);
        wait_done(60, cyc);
        check("t4d_iter", iter_cnt, 1);
        check("t4d_conv", converged, 1);
        check("t4d_sat", sat, 0);
        report(cyc);
        @(negedge clk);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_err", err_code, 0);
        @(negedge clk);

        // JI never completes.
        set_fk(0, 0, 0);
        hang_mask = 5'b00100;
        do_run(50, 50, 0, 1'b0);
`ifdef IK_WATCHDOG_EN
        wait_done(100, cyc);
        check("t5_fault_latency", cyc, 14);
        check("t5_err", err_code, 1);
        check("t5_stage_en", stage_en, 0);
        check("t5_busy", busy, 0);
        check("t5_conv", converged, 0);
`else
        repeat (40) @(negedge clk);
        check("t5_still_busy", busy, 1);
        check("t5_stage_en_ji", stage_en, 5'b00100);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(2, cyc);
        check("t5_err", err_code, 3);
        check("t5_busy", busy, 0);
`endif
        report(cyc);
        hang_mask = 5'b00000;
        @(negedge clk);

        // Abort during MULT with a stray start pulse earlier in the run.
        do_run(50, 50, 0, 1'b0);
        c = 0;
        while (c < 20 && stage_en !== 5'b01000) begin
            start = (c == 4);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        check("t6_mult_reached_at", c, 8);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(2, cyc);
        check("t6_abort_latency", cyc, 0);
        check("t6_err", err_code, 3);
        check("t6_conv", converged, 0);
        check("t6_iter", iter_cnt, 0);
        report(cyc + 1);
        @(negedge clk);

        // Reset mid-run discards everything, including the absolute position.
        d1_steps = 9'sd5; d2_steps = 9'sd5;
        do_run(50, 50, 0, 1'b0);
        repeat (13) @(negedge clk);
        check("t7_busy_before_reset", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("t7_th1", th1_steps, 0);
        check("t7_th2", th2_steps, 0);
        check("t7_busy", busy, 0);
        check("t7_stage_rst", stage_rst, 1);
        check("t7_stage_en", stage_en, 0);
        check("t7_iter", iter_cnt, 0);
        check("t7_sat", sat, 0);
        check("t7_err", err_code, 0);
        reset = 1'b0;
        @(negedge clk);

        set_fk(0, 1, 1);
        do_run(1, 1, 0, 1'b0);
        wait_done(20, cyc);
        check("t8_conv", converged, 1);
        check("t8_th1", th1_steps, 0);
        report(cyc);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scara_ik_sequencer.md
# scara_ik_sequencer

Parametrised iterative inverse-kinematics sequencer for the SCARA arm. Drives the five compute stages (FK, J, JI, MULT, CONV) through a one-hot enable / per-stage done handshake. Repeats the Jacobian-inverse loop until the FK position is within tolerance of the target or an iteration limit is hit. Accumulates per-iteration joint step deltas into saturating absolute step commands for the stepper drivers.

## Interface
- COORD_W, 14: signed coordinate width (x/y target, FK result, tolerance)
- STEP_W, 9: signed step delta / accumulator width
- MAX_ITER, 16: maximum Jacobian iterations per run (≥1)
- TIMEOUT_CYC, 1024: per-stage watchdog limit in cycles (≥2)
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high
- start  in  1  run request; accepted only in IDLE
- abort  in  1  terminate the current run
- x_target, y_target  in  COORD_W  signed target position, sampled on accepted start
- tol  in  COORD_W  unsigned convergence tolerance, sampled on accepted start
- x_fk, y_fk  in  COORD_W  signed FK result; valid with stage_done[0]
- d1_steps, d2_steps  in  STEP_W  signed CONV result; valid with stage_done[4]
- stage_done  in  5  per-stage done: bit 0 FK, 1 J, 2 JI, 3 MULT, 4 CONV
- stage_en  out  5  one-hot stage enable, same bit order
- stage_rst  out  1  stage reset pulse
- th1_steps, th2_steps  out  STEP_W  signed accumulated step commands
- step_valid  out  1  one-cycle pulse when th*_steps update
- busy  out  1  high from the cycle after start acceptance until the DONE/FAULT cycle
- done  out  1  one-cycle completion pulse
- converged  out  1  last run met tolerance; held until next start
- sat  out  1  sticky accumulator saturation; cleared on start
- err_code  out  2  00 ok, 01 watchdog timeout, 10 iteration limit, 11 aborted; held until next start
- iter_cnt  out  $clog2(MAX_ITER+1)  completed iterations in current/last run

## Operation
- Reset values: stage_en=0, stage_rst=1, th1/th2_steps=0, step_valid=0, busy=0, done=0, converged=0, sat=0, err_code=00, iter_cnt=0, state IDLE.
- States: IDLE, PREP, RUN, CHECK, ACCUM, DONE, FAULT. Current-stage register cur ∈ {FK..CONV}.
- IDLE: stage_rst=1. On start, latch targets/tol; clear iter_cnt, sat, converged, err_code; cur=FK; go PREP.
- PREP (1 cycle): stage_rst=1, stage_en=0, watchdog cleared; go RUN.
- RUN: stage_en[cur]=1, stage_rst=0. Only stage_done[cur] is observed; other bits are ignored. On done: FK→CHECK; CONV→ACCUM; else cur=next stage, go PREP.
- CHECK: ex=|x_target−x_fk|, ey=|y_target−y_fk| computed at COORD_W+1 bits (no overflow). ex≤tol and ey≤tol → converged=1, err_code=00, DONE. Otherwise, iter_cnt==MAX_ITER → err_code=10, DONE. Otherwise cur=J, PREP.
- ACCUM: th1+=d1, th2+=d2 with signed saturation to [−2^(STEP_W−1), 2^(STEP_W−1)−1]; any clamp sets sat. step_valid=1; iter_cnt+=1; cur=FK; go PREP.
- DONE: done=1 for one cycle, busy=0; go IDLE. FAULT: done=1, err_code=01; go IDLE.
- abort in PREP/RUN/CHECK/ACCUM: err_code=11, go DONE next cycle. An ACCUM cycle coinciding with abort still commits its accumulation. abort in IDLE is ignored.
- start while busy: ignored. start and abort together in IDLE: start wins, abort ignored.
- th*_steps persist across runs (absolute position). Only reset clears them.
- reset mid-run: all outputs return to reset values next edge; in-flight stage results are discarded.

## Timing
- Per stage: 1 PREP + n RUN cycles, where n is the RUN cycle in which done is seen (n≥1).
- stage_en[cur] rises the edge after PREP and falls the edge after stage_done[cur] is sampled.
- Run latency for k iterations = Σ(PREP+RUN) over all stages + k ACCUM + (k+1) CHECK + 1 DONE.
- step_valid coincides with the first cycle th*_steps show new values.
- Watchdog: RUN cycle count reaching TIMEOUT_CYC without done → FAULT next edge. stage_en drops on the same edge.

## Configuration
- IK_WATCHDOG_EN defined: watchdog counter present; FAULT reachable; err_code 01 possible.
- IK_WATCHDOG_EN undefined: no counter; RUN waits indefinitely; TIMEOUT_CYC ignored; FAULT state unreachable; err_code never 01.

## Structure
- scara_pkg holds: stage enum (FK, J, JI, MULT, CONV) with bit indices, sequencer state enum, err_code enum.
- One sub-module, step_accumulator: saturating signed add of STEP_W operands with a clamp flag, instantiated once per joint.

## Test plan
- Stub stages done in 1 cycle; FK returns target exactly on the first pass → converged=1, err_code=00, iter_cnt=0, no step_valid, done pulses once.
- Target (100,50), tol=2; FK returns (90,40) then (99,49); CONV returns d1=3, d2=−2 → one step_valid, th1=3, th2=−2, iter_cnt=1, converged=1.
- MAX_ITER=4, FK never within tol → 4 step_valid pulses, err_code=10, converged=0.
- STEP_W=9, th1=250, CONV d1=10 → th1=255, sat=1; sat clears on next start.
- IK_WATCHDOG_EN, TIMEOUT_CYC=8, JI never done → FAULT, err_code=01, stage_en=0, done pulse. Without macro, busy stays high until abort.
- abort asserted mid-MULT → err_code=11 within 2 cycles; a second start pulse during the run is ignored; reset mid-run zeroes th*_steps.
